// File: rtl/bist_pattern_misr_ctrl.sv
// rtl/bist_pattern_misr_ctrl.sv - LFSR pattern driver and MISR signature compactor for netlist self-test
// One pattern per clock from a Galois LFSR; responses folded into a Galois MISR and compared to golden.
module bist_pattern_misr_ctrl #(
    parameter int               IN_W      = 16,
    parameter int               OUT_W     = 23,
    parameter int               PATTERNS  = 256,
    parameter logic [IN_W-1:0]  SEED      = 16'h0001,
    parameter logic [IN_W-1:0]  LFSR_POLY = 16'hB400,
    parameter logic [OUT_W-1:0] MISR_POLY = 23'h420000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pat_count
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [IN_W-1:0] SEED_EFF  = (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
    localparam logic [15:0]     LAST_IDX  = 16'(PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             load;
    logic             absorb;
    logic             last_pattern;
    logic             match;
    logic             pass_hold;
    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;

    assign load         = (state == ST_IDLE) && start;
    assign absorb       = (state == ST_RUN) && !abort;
    assign last_pattern = (pat_count == LAST_IDX);
    assign match        = (signature == golden);

    assign lfsr_next = (dut_in >> 1) ^ (dut_in[0] ? LFSR_POLY : '0);
    assign misr_next = (signature >> 1) ^ (signature[0] ? MISR_POLY : '0) ^ dut_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_pattern) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in    <= '0;
            signature <= '0;
            pat_count <= '0;
            pass_hold <= 1'b0;
        end else if (load) begin
            dut_in    <= SEED_EFF;
            signature <= '0;
            pat_count <= '0;
            pass_hold <= 1'b0;
        end else if (absorb) begin
            dut_in    <= lfsr_next;
            signature <= misr_next;
            pat_count <= pat_count + 16'd1;
        end else if (state == ST_DONE) begin
            pass_hold <= match;
        end
    end

    // pass is live during the done cycle and held afterwards until the next start.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = (state == ST_DONE) ? match : pass_hold;

endmodule

// File: tb/tb_bist_pattern_misr_ctrl.sv
// tb/tb_bist_pattern_misr_ctrl.sv - self-checking bench for bist_pattern_misr_ctrl against a sequence/fold model
module tb_bist_pattern_misr_ctrl;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [22:0] MISR_POLY = 23'h420000;
    localparam int          NPAT      = 256;
    localparam logic [15:0] MAIN_SEED = 16'h1D2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        start_a, abort_a, busy_a, done_a, pass_a;
    logic [22:0] golden_a, dut_out_a, sig_a, flip_mask;
    logic [15:0] dut_in_a, cnt_a;

    logic        start_b, abort_b, busy_b, done_b, pass_b;
    logic [22:0] golden_b, dut_out_b, sig_b;
    logic [15:0] dut_in_b, cnt_b;

    logic        start_c, abort_c, busy_c, done_c, pass_c;
    logic [22:0] golden_c, dut_out_c, sig_c;
    logic [15:0] dut_in_c, cnt_c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] seq [NPAT];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_POLY : 16'h0);
    endfunction

    function automatic logic [22:0] netlist(input logic [15:0] x);
        logic [15:0] lo;
        lo = x ^ (x << 3) ^ {x[0], x[15:1]};
        return {x[6:0] ^ x[15:9], lo};
    endfunction

    function automatic logic [22:0] misr_of(input int n, input int flip_at, input logic [22:0] flip);
        logic [22:0] s;
        logic [22:0] r;
        s = '0;
        for (int i = 0; i < n; i++) begin
            r = netlist(seq[i]) ^ ((i == flip_at) ? flip : 23'h0);
            s = (s >> 1) ^ (s[0] ? MISR_POLY : 23'h0) ^ r;
        end
        return s;
    endfunction

    assign dut_out_a = netlist(dut_in_a) ^ flip_mask;
    assign dut_out_b = 23'h1;
    assign dut_out_c = 23'h1;

    bist_pattern_misr_ctrl #(.PATTERNS(NPAT), .SEED(MAIN_SEED)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .golden(golden_a),
        .dut_out(dut_out_a), .dut_in(dut_in_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .pat_count(cnt_a)
    );

    bist_pattern_misr_ctrl #(.PATTERNS(2), .SEED(16'h0000)) u_p2 (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .golden(golden_b),
        .dut_out(dut_out_b), .dut_in(dut_in_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .pat_count(cnt_b)
    );

    bist_pattern_misr_ctrl #(.PATTERNS(1), .SEED(16'h0001)) u_p1 (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .golden(golden_c),
        .dut_out(dut_out_c), .dut_in(dut_in_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c), .pat_count(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_main(input logic [22:0] gold, input int flip_at,
                            input logic [22:0] flip, input bit poke_start);
        logic [22:0] exp_sig;
        exp_sig  = misr_of(NPAT, flip_at, flip);
        golden_a = gold;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        for (int i = 0; i < NPAT; i++) begin
            check("run_busy", busy_a, 1);
            check("run_dut_in", dut_in_a, seq[i]);
            check("run_pat_count", cnt_a, i);
            check("run_done_low", done_a, 0);
            if (poke_start && i == 50) start_a = 1'b1;
            if (i == flip_at) flip_mask = flip;
            tick();
            start_a   = 1'b0;
            flip_mask = '0;
        end
        check("end_done", done_a, 1);
        check("end_busy", busy_a, 0);
        check("end_signature", sig_a, exp_sig);
        check("end_pass", pass_a, (exp_sig == gold));
        check("end_pat_count", cnt_a, NPAT);
        if (poke_start) start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("idle_done", done_a, 0);
        check("idle_busy", busy_a, 0);
        check("idle_pass_held", pass_a, (exp_sig == gold));
        check("idle_sig_held", sig_a, exp_sig);
        tick();
        check("idle_busy2", busy_a, 0);
        check("idle_cnt_held", cnt_a, NPAT);
    endtask

    initial begin
        logic [22:0] clean_sig;
        logic [15:0] x;
        bit          lfsr_ok;
        bit          seen [65536];
        int          fa, fb;

        rst = 1'b1;
        start_a = 0; abort_a = 0; golden_a = '0; flip_mask = '0;
        start_b = 0; abort_b = 0; golden_b = '0;
        start_c = 0; abort_c = 0; golden_c = '0;
        seq[0] = MAIN_SEED;
        for (int i = 1; i < NPAT; i++) seq[i] = lfsr_next(seq[i-1]);
        clean_sig = misr_of(NPAT, -1, 23'h0);

        tick();
        tick();
        rst = 1'b0;
        check("rst_dut_in", dut_in_a, 0);
        check("rst_signature", sig_a, 0);
        check("rst_pat_count", cnt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);

        lfsr_ok = 1'b1;
        x = 16'h0001;
        for (int i = 0; i < 65535; i++) begin
            if (x == 16'h0 || seen[x]) lfsr_ok = 1'b0;
            seen[x] = 1'b1;
            x = lfsr_next(x);
        end
        check("lfsr_period", {31'h0, lfsr_ok && (x == 16'h0001)}, 1);

        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("p1_busy", busy_c, 1);
        check("p1_dut_in", dut_in_c, 16'h0001);
        tick();
        check("p1_done", done_c, 1);
        check("p1_busy_off", busy_c, 0);
        check("p1_signature", sig_c, 23'h000001);
        check("p1_pat_count", cnt_c, 1);
        tick();
        check("p1_done_pulse", done_c, 0);

        for (int k = 0; k < 2; k++) begin
            golden_b = (k == 0) ? 23'h420001 : 23'h0;
            start_b  = 1'b1;
            tick();
            start_b  = 1'b0;
            check("p2_seed0_dut_in", dut_in_b, 16'h0001);
            tick();
            check("p2_dut_in2", dut_in_b, 16'hB400);
            tick();
            check("p2_done", done_b, 1);
            check("p2_signature", sig_b, 23'h420001);
            check("p2_pass", pass_b, (k == 0));
            tick();
        end

        run_main(clean_sig, -1, 23'h0, 1'b0);

        fa = $urandom_range(0, NPAT-1);
        fb = $urandom_range(0, 22);
        run_main(clean_sig, fa, 23'h1 << fb, 1'b1);

        run_main(23'($urandom), -1, 23'h0, 1'b0);

        golden_a = clean_sig;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        repeat (5) tick();
        check("abort_at5", cnt_a, 5);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_cnt", cnt_a, 5);
        check("abort_sig", sig_a, misr_of(5, -1, 23'h0));
        check("abort_dut_in", dut_in_a, seq[5]);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", done_a, 0);
            check("abort_pass", pass_a, 0);
            tick();
        end

        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (100) tick();
        check("midrun_cnt", cnt_a, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_dut_in", dut_in_a, 0);
        check("midrst_sig", sig_a, 0);
        check("midrst_cnt", cnt_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_pass", pass_a, 0);
        run_main(clean_sig, -1, 23'h0, 1'b0);

        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_wins_busy", busy_a, 1);
        check("start_wins_cnt", cnt_a, 0);
        check("start_wins_dut_in", dut_in_a, MAIN_SEED);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
